ex_mem: RTL and testbench
=========================

Name: ex_mem

Overview:
- EX/MEM pipeline register of the 5-stage pipelined MIPS-style CPU. It sits between the execute stage and the memory stage.
- Each clock it captures the EX-stage control bits, ALU zero flag, ALU result, store data (read2) and destination register number, and presents them to the MEM stage one cycle later.
- Supports stall (hold) and flush (bubble insertion) for hazard handling.

Parameters:
- DATA_W, 32, width of aluResult and read2 paths.
- REG_W, 5, width of destination register index.

Ports:
- clk  input  1  system clock, rising-edge active.
- startin  input  1  asynchronous, active-low reset.
- stall  input  1  hold all outputs at current value.
- flush  input  1  load a bubble (all outputs 0) on the next edge.
- jumpIn, branchIn, memreadIn, memtoregIn, memwriteIn, regwriteIn  input  1 each  EX-stage control bits.
- zeroIn  input  1  ALU zero flag.
- aluResultIn  input  DATA_W  ALU result.
- regDstMuxIn  input  REG_W  selected destination register.
- read2In  input  DATA_W  register-file read port 2 data (store data).
- jump, branch, memread, memtoreg, memwrite, regwrite  output  1 each  registered control bits.
- zero  output  1  registered zero flag.
- aluResult  output  DATA_W  registered ALU result.
- regDstMux  output  REG_W  registered destination register.
- read2  output  DATA_W  registered store data.

Behaviour:
- One clock (clk) and an asynchronous, active-low reset (startin). All outputs are flops, with no combinational input-to-output path.
- Reset: while startin=0, every output is 0 immediately, without waiting for a clock edge.
- Reset release is synchronous in effect: the first rising edge after startin goes high performs a normal update.
- Update priority at each rising clk edge, with startin=1:
  - flush=1: all outputs load 0 (controls, zero, aluResult, regDstMux, read2). flush wins over stall.
  - else stall=1: all outputs hold.
  - else: every output loads its corresponding *In input.
- Latency: exactly 1 cycle, input to output.
- Inputs changing between edges have no effect on the outputs.
- Reset asserted mid-operation clears outputs asynchronously. This overrides any pending stall or flush.
- Widths are passed straight through, with no arithmetic, truncation or extension.
- X on stall/flush while startin=0 is don't-care.

Optional Feature:
- Macro EX_MEM_BRTARGET_EN.
- When defined, two extra ports are added:
  - branchTargetIn  input  DATA_W
  - branchTarget  output  DATA_W
- branchTarget follows the same rules as aluResult:
  - reset to 0
  - flush to 0
  - hold on stall
  - else capture branchTargetIn
- When undefined, these ports do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset: startin=0 with inputs jumpIn=1, branchIn=0, memreadIn=1, memtoregIn=0, memwriteIn=1, regwriteIn=0, zeroIn=1, aluResultIn=0, regDstMuxIn=10, read2In=8 -> all outputs 0 with no clock edge needed.
- Capture: release startin to 1, stall=0, flush=0 -> after first rising edge, jump=1, branch=0, memread=1, memtoreg=0, memwrite=1, regwrite=0, zero=1, aluResult=0, regDstMux=10, read2=8.
- Stall: hold stall=1, change aluResultIn to 0x1234, regDstMuxIn to 3 -> outputs unchanged (aluResult=0, regDstMux=10). Deassert stall -> next edge gives aluResult=0x1234, regDstMux=3.
- Flush priority: stall=1 and flush=1 together on an edge -> all outputs 0. Next edge with both low -> current inputs captured.
- Async reset mid-run: pull startin low between edges while outputs are nonzero -> outputs go to 0 immediately and stay 0 across edges until startin returns high.
- EX_MEM_BRTARGET_EN build: branchTargetIn=0x00400010 -> branchTarget=0x00400010 after one edge; stall holds it; flush gives 0.

Source files
------------

// File: rtl/ex_mem.sv
// EX/MEM pipeline register of the 5-stage MIPS-style CPU.
// Captures the execute-stage control bits, ALU zero flag, ALU result, store data
// and destination register, and presents them to the memory stage one cycle later.
// Every output is a flop, so there is no combinational path from input to output.
// At each edge a flush loads a bubble, a stall holds, and otherwise the inputs are captured.
// Optional feature: define EX_MEM_BRTARGET_EN to also pipeline a branch target
// (branchTargetIn -> branchTarget) with the same reset, flush and stall rules.
module ex_mem #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              startin,
    input  logic              stall,
    input  logic              flush,
    input  logic              jumpIn,
    input  logic              branchIn,
    input  logic              memreadIn,
    input  logic              memtoregIn,
    input  logic              memwriteIn,
    input  logic              regwriteIn,
    input  logic              zeroIn,
    input  logic [DATA_W-1:0] aluResultIn,
    input  logic [REG_W-1:0]  regDstMuxIn,
    input  logic [DATA_W-1:0] read2In,
`ifdef EX_MEM_BRTARGET_EN
    input  logic [DATA_W-1:0] branchTargetIn,
    output logic [DATA_W-1:0] branchTarget,
`endif
    output logic              jump,
    output logic              branch,
    output logic              memread,
    output logic              memtoreg,
    output logic              memwrite,
    output logic              regwrite,
    output logic              zero,
    output logic [DATA_W-1:0] aluResult,
    output logic [REG_W-1:0]  regDstMux,
    output logic [DATA_W-1:0] read2
);

    // Group the six control bits so that reset, flush and capture handle them as one field.
    typedef struct packed {
        logic jump;
        logic branch;
        logic memread;
        logic memtoreg;
        logic memwrite;
        logic regwrite;
    } ctrl_t;

    ctrl_t ctrl_in;
    ctrl_t ctrl_q;

    // Pack the incoming control bits into the struct.
    always_comb begin
        ctrl_in          = '0;
        ctrl_in.jump     = jumpIn;
        ctrl_in.branch   = branchIn;
        ctrl_in.memread  = memreadIn;
        ctrl_in.memtoreg = memtoregIn;
        ctrl_in.memwrite = memwriteIn;
        ctrl_in.regwrite = regwriteIn;
    end

    // Pipeline register. Reset clears it asynchronously, a flush wins over a stall,
    // a stall holds the value, and otherwise the EX-stage values are captured.
    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            ctrl_q       <= '0;
            zero         <= 1'b0;
            aluResult    <= '0;
            regDstMux    <= '0;
            read2        <= '0;
`ifdef EX_MEM_BRTARGET_EN
            branchTarget <= '0;
`endif
        end else if (flush) begin
            ctrl_q       <= '0;
            zero         <= 1'b0;
            aluResult    <= '0;
            regDstMux    <= '0;
            read2        <= '0;
`ifdef EX_MEM_BRTARGET_EN
            branchTarget <= '0;
`endif
        end else if (!stall) begin
            ctrl_q       <= ctrl_in;
            zero         <= zeroIn;
            aluResult    <= aluResultIn;
            regDstMux    <= regDstMuxIn;
            read2        <= read2In;
`ifdef EX_MEM_BRTARGET_EN
            branchTarget <= branchTargetIn;
`endif
        end
    end

    // Drive the registered control bits out to the MEM stage.
    always_comb begin
        jump     = ctrl_q.jump;
        branch   = ctrl_q.branch;
        memread  = ctrl_q.memread;
        memtoreg = ctrl_q.memtoreg;
        memwrite = ctrl_q.memwrite;
        regwrite = ctrl_q.regwrite;
    end

endmodule

// File: tb/tb_ex_mem.sv
// Directed testbench for ex_mem. It covers reset, capture, stall, flush priority
// and asynchronous reset in the middle of operation, and checks the branch target
// path as well when EX_MEM_BRTARGET_EN is defined.
module tb_ex_mem;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic clk = 1'b0;
    logic startin, stall, flush;
    logic jumpIn, branchIn, memreadIn, memtoregIn, memwriteIn, regwriteIn, zeroIn;
    logic [DATA_W-1:0] aluResultIn, read2In;
    logic [REG_W-1:0]  regDstMuxIn;
    logic jump, branch, memread, memtoreg, memwrite, regwrite, zero;
    logic [DATA_W-1:0] aluResult, read2;
    logic [REG_W-1:0]  regDstMux;
`ifdef EX_MEM_BRTARGET_EN
    logic [DATA_W-1:0] branchTargetIn, branchTarget;
`endif

    int total = 0;
    int bad   = 0;

    ex_mem #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .startin(startin), .stall(stall), .flush(flush),
        .jumpIn(jumpIn), .branchIn(branchIn), .memreadIn(memreadIn),
        .memtoregIn(memtoregIn), .memwriteIn(memwriteIn), .regwriteIn(regwriteIn),
        .zeroIn(zeroIn), .aluResultIn(aluResultIn), .regDstMuxIn(regDstMuxIn),
        .read2In(read2In),
`ifdef EX_MEM_BRTARGET_EN
        .branchTargetIn(branchTargetIn), .branchTarget(branchTarget),
`endif
        .jump(jump), .branch(branch), .memread(memread), .memtoreg(memtoreg),
        .memwrite(memwrite), .regwrite(regwrite), .zero(zero),
        .aluResult(aluResult), .regDstMux(regDstMux), .read2(read2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against hand-computed values; ctl = {jump,branch,memread,memtoreg,memwrite,regwrite}
    task automatic chk_all(input string tag, input logic [5:0] ctl, input logic z,
                           input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] r2);
        chk({tag, ".ctl"}, {26'd0, jump, branch, memread, memtoreg, memwrite, regwrite}, {26'd0, ctl});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
        chk({tag, ".alu"}, aluResult, alu);
        chk({tag, ".rd"}, {27'd0, regDstMux}, {27'd0, rd});
        chk({tag, ".read2"}, read2, r2);
    endtask

    task automatic set_in(input logic [5:0] ctl, input logic z, input logic [31:0] alu,
                          input logic [4:0] rd, input logic [31:0] r2);
        {jumpIn, branchIn, memreadIn, memtoregIn, memwriteIn, regwriteIn} = ctl;
        zeroIn = z; aluResultIn = alu; regDstMuxIn = rd; read2In = r2;
    endtask

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset is asserted at time 0 and the outputs must already be zero before the first edge.
        startin = 1'b0; stall = 1'b0; flush = 1'b0;
        set_in(6'b101010, 1'b1, 32'h0, 5'd10, 32'h8);
`ifdef EX_MEM_BRTARGET_EN
        branchTargetIn = 32'h0040_0010;
`endif
        #2;
        chk_all("reset_noedge", 6'b0, 1'b0, 32'h0, 5'd0, 32'h0);
`ifdef EX_MEM_BRTARGET_EN
        chk("reset_bt", branchTarget, 32'h0);
`endif
        edge_then_sample();
        chk_all("reset_edge", 6'b0, 1'b0, 32'h0, 5'd0, 32'h0);

        // Release reset between edges; the next edge captures the inputs.
        #2 startin = 1'b1;
        edge_then_sample();
        chk_all("capture", 6'b101010, 1'b1, 32'h0, 5'd10, 32'h8);
`ifdef EX_MEM_BRTARGET_EN
        chk("capture_bt", branchTarget, 32'h0040_0010);
`endif

        // Stall: change inputs, which must not show between edges or on the stalled edge.
        stall = 1'b1;
        set_in(6'b101010, 1'b1, 32'h1234, 5'd3, 32'h8);
`ifdef EX_MEM_BRTARGET_EN
        branchTargetIn = 32'hDEAD_BEEF;
`endif
        #2;
        chk_all("between_edges", 6'b101010, 1'b1, 32'h0, 5'd10, 32'h8);
        edge_then_sample();
        chk_all("stall_hold", 6'b101010, 1'b1, 32'h0, 5'd10, 32'h8);
`ifdef EX_MEM_BRTARGET_EN
        chk("stall_bt", branchTarget, 32'h0040_0010);
`endif
        stall = 1'b0;
        edge_then_sample();
        chk_all("unstall", 6'b101010, 1'b1, 32'h1234, 5'd3, 32'h8);
`ifdef EX_MEM_BRTARGET_EN
        chk("unstall_bt", branchTarget, 32'hDEAD_BEEF);
`endif

        // Flush wins over stall. Use full-width inputs so that any surviving bit would be visible.
        set_in(6'b111111, 1'b1, 32'hFFFF_FFFF, 5'd31, 32'hA5A5_A5A5);
`ifdef EX_MEM_BRTARGET_EN
        branchTargetIn = 32'h1234_5678;
`endif
        stall = 1'b1; flush = 1'b1;
        edge_then_sample();
        chk_all("flush_over_stall", 6'b0, 1'b0, 32'h0, 5'd0, 32'h0);
`ifdef EX_MEM_BRTARGET_EN
        chk("flush_bt", branchTarget, 32'h0);
`endif
        stall = 1'b0; flush = 1'b0;
        edge_then_sample();
        chk_all("after_flush", 6'b111111, 1'b1, 32'hFFFF_FFFF, 5'd31, 32'hA5A5_A5A5);
`ifdef EX_MEM_BRTARGET_EN
        chk("after_flush_bt", branchTarget, 32'h1234_5678);
`endif

        // Flush alone, then capture again.
        flush = 1'b1;
        edge_then_sample();
        chk_all("flush_only", 6'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        flush = 1'b0;
        edge_then_sample();
        chk_all("recapture", 6'b111111, 1'b1, 32'hFFFF_FFFF, 5'd31, 32'hA5A5_A5A5);

        // Async reset in the middle of a cycle clears the outputs immediately and overrides stall/flush.
        #2 startin = 1'b0;
        #1;
        chk_all("async_reset", 6'b0, 1'b0, 32'h0, 5'd0, 32'h0);
`ifdef EX_MEM_BRTARGET_EN
        chk("async_reset_bt", branchTarget, 32'h0);
`endif
        edge_then_sample();
        chk_all("reset_hold_edge", 6'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        stall = 1'b1;
        edge_then_sample();
        chk_all("reset_over_stall", 6'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        stall = 1'b0;

        // Release again with a new pattern; the first edge after release is a normal update.
        set_in(6'b010101, 1'b0, 32'h8000_0001, 5'd17, 32'h0000_FFFF);
        #2 startin = 1'b1;
        edge_then_sample();
        chk_all("release_capture", 6'b010101, 1'b0, 32'h8000_0001, 5'd17, 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #5000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
